// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC write path: sequencer state encoding,
// default bus addresses/command bytes and time-field index names.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIELD = 2'd1,
        ST_GAP   = 2'd2,
        ST_CMD   = 2'd3
    } wr_state_t;

    localparam logic [7:0] RTC_CLK_BASE_ADDR = 8'h21;
    localparam logic [7:0] RTC_TMR_BASE_ADDR = 8'h41;
    localparam logic [7:0] RTC_CMD_CLK_ADDR  = 8'hF1;
    localparam logic [7:0] RTC_CMD_TMR_ADDR  = 8'hF2;
    localparam logic [7:0] RTC_CMD_DATA      = 8'h01;

    localparam int FLD_SEC   = 0;
    localparam int FLD_MIN   = 1;
    localparam int FLD_HOUR  = 2;
    localparam int FLD_DAY   = 3;
    localparam int FLD_MONTH = 4;
    localparam int FLD_YEAR  = 5;

endpackage

// File: rtl/rtc_field_pick.sv
// Combinational priority encoder: lowest set mask bit at or above start_idx.
// Returns N in next_idx with found=0 when no such bit exists.
module rtc_field_pick #(
    parameter int N  = 6,
    parameter int IW = $clog2(N + 1)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start_idx,
    output logic [IW-1:0] next_idx,
    output logic          found
);

    logic [N-1:0] elig;

    for (genvar gi = 0; gi < N; gi++) begin : g_elig
        assign elig[gi] = mask[gi] && (IW'(gi) >= start_idx);
    end

    // Scan from the top so the lowest eligible index wins.
    always_comb begin
        next_idx = IW'(N);
        found    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                next_idx = IW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_wr_sequencer.sv
// Walks the masked RTC time fields, emitting address/data byte pairs, then the transfer command.
// Define RTC_WR_BCD_CHECK_EN to reject starts whose masked fields are not valid BCD (err pulse).
module rtc_wr_sequencer
    import rtc_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                N_FIELDS      = FLD_YEAR + 1,
    parameter int                TMR_FIELDS    = FLD_HOUR + 1,
    parameter logic [DATA_W-1:0] CLK_BASE_ADDR = DATA_W'(RTC_CLK_BASE_ADDR),
    parameter logic [DATA_W-1:0] TMR_BASE_ADDR = DATA_W'(RTC_TMR_BASE_ADDR),
    parameter logic [DATA_W-1:0] CMD_CLK_ADDR  = DATA_W'(RTC_CMD_CLK_ADDR),
    parameter logic [DATA_W-1:0] CMD_TMR_ADDR  = DATA_W'(RTC_CMD_TMR_ADDR),
    parameter logic [DATA_W-1:0] CMD_DATA      = DATA_W'(RTC_CMD_DATA)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           mode_clk,
    input  logic [N_FIELDS-1:0]            field_mask,
    input  logic [N_FIELDS*DATA_W-1:0]     field_data,
    input  logic                           addr_phase,
    input  logic                           data_phase,
    input  logic                           phase_done,
    input  logic                           abort,
    output logic                           wr_en,
    output logic [DATA_W-1:0]              wr_byte,
    output logic                           busy,
    output logic [$clog2(N_FIELDS+1)-1:0]  cur_field,
    output logic                           wr_done,
    output logic                           err
);

    localparam int IW = $clog2(N_FIELDS + 1);

    wr_state_t           state_q, state_d;
    logic [N_FIELDS-1:0] mask_q, mask_d;
    logic                mode_q, mode_d;
    logic [IW-1:0]       cur_field_q, cur_field_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_byte_q, wr_byte_d;
    logic                wr_done_q, wr_done_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   fld [N_FIELDS];
    logic [N_FIELDS-1:0] eff_mask;
    logic [N_FIELDS-1:0] bcd_bad_vec;
    logic                bcd_bad;
    logic [N_FIELDS-1:0] pick_mask;
    logic [IW-1:0]       pick_start;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;
    logic [DATA_W-1:0]   field_byte;
    logic [DATA_W-1:0]   base_addr;

    for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
        assign fld[gi] = field_data[gi*DATA_W +: DATA_W];
        // Fields beyond the timer set only exist in clock mode.
        if (gi < TMR_FIELDS) begin : g_tmr
            assign eff_mask[gi] = field_mask[gi];
        end else begin : g_clk_only
            assign eff_mask[gi] = field_mask[gi] & mode_clk;
        end
`ifdef RTC_WR_BCD_CHECK_EN
        assign bcd_bad_vec[gi] = (fld[gi][3:0] > 4'd9) || (fld[gi][7:4] > 4'd9);
`else
        assign bcd_bad_vec[gi] = 1'b0;
`endif
    end

    assign bcd_bad = |(bcd_bad_vec & eff_mask);

    // One encoder serves both the initial pick (live mask) and the GAP step (latched mask).
    assign pick_mask  = (state_q == ST_IDLE) ? eff_mask : mask_q;
    assign pick_start = (state_q == ST_IDLE) ? '0 : cur_field_q + IW'(1);

    rtc_field_pick #(
        .N  (N_FIELDS),
        .IW (IW)
    ) u_pick (
        .mask      (pick_mask),
        .start_idx (pick_start),
        .next_idx  (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        field_byte = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (cur_field_q == IW'(i)) field_byte = fld[i];
        end
    end

    assign base_addr = mode_q ? CLK_BASE_ADDR : TMR_BASE_ADDR;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        cur_field_d = cur_field_q;
        wr_byte_d   = wr_byte_q;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bcd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mask_d      = eff_mask;
                        mode_d      = mode_clk;
                        cur_field_d = pick_idx;
                        state_d     = pick_found ? ST_FIELD : ST_CMD;
                    end
                end
            end
            ST_FIELD: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    cur_field_d = '0;
                end else if (addr_phase) begin
                    wr_byte_d = base_addr + DATA_W'(cur_field_q);
                end else if (data_phase) begin
                    wr_byte_d = field_byte;
                end else if (phase_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    cur_field_d = '0;
                end else begin
                    cur_field_d = pick_idx;
                    state_d     = pick_found ? ST_FIELD : ST_CMD;
                end
            end
            ST_CMD: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    cur_field_d = '0;
                end else if (addr_phase) begin
                    wr_byte_d = mode_q ? CMD_CLK_ADDR : CMD_TMR_ADDR;
                end else if (data_phase) begin
                    wr_byte_d = CMD_DATA;
                end else if (phase_done) begin
                    wr_done_d   = 1'b1;
                    state_d     = ST_IDLE;
                    cur_field_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_en_d = (state_d == ST_FIELD) || (state_d == ST_CMD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            cur_field_q <= '0;
            wr_en_q     <= 1'b0;
            wr_byte_q   <= '0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            cur_field_q <= cur_field_d;
            wr_en_q     <= wr_en_d;
            wr_byte_q   <= wr_byte_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_byte   = wr_byte_q;
    assign busy      = (state_q != ST_IDLE);
    assign cur_field = cur_field_q;
    assign wr_done   = wr_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rtc_wr_sequencer.sv
// Directed bench for rtc_wr_sequencer: table of full write sequences plus hand-written corner cases.
module tb_rtc_wr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_clk;
    logic [5:0]  field_mask;
    logic [47:0] field_data;
    logic        addr_phase;
    logic        data_phase;
    logic        phase_done;
    logic        abort;
    logic        wr_en;
    logic [7:0]  wr_byte;
    logic        busy;
    logic [2:0]  cur_field;
    logic        wr_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // idx: expected field indices, first in the MSBs; bytes: expected wr_byte stream, first in the MSBs.
    typedef struct packed {
        logic         mode;
        logic [5:0]   mask;
        logic [3:0]   nf;
        logic [17:0]  idx;
        logic [111:0] bytes;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    rtc_wr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_clk   (mode_clk),
        .field_mask (field_mask),
        .field_data (field_data),
        .addr_phase (addr_phase),
        .data_phase (data_phase),
        .phase_done (phase_done),
        .abort      (abort),
        .wr_en      (wr_en),
        .wr_byte    (wr_byte),
        .busy       (busy),
        .cur_field  (cur_field),
        .wr_done    (wr_done),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int b = 0;
        mode_clk   = v.mode;
        field_mask = v.mask;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Scramble the live inputs: the DUT must work from its latched copies.
        mode_clk   = ~v.mode;
        field_mask = 6'b000000;
        check("start_busy", busy, 1);
        check("start_wr_en", wr_en, 1);
        for (int k = 0; k < int'(v.nf); k++) begin
            check("fld_cur_field", cur_field, v.idx[17-3*k -: 3]);
            addr_phase = 1'b1; tick(); addr_phase = 1'b0;
            check("fld_addr", wr_byte, v.bytes[111-8*b -: 8]); b++;
            data_phase = 1'b1; tick(); data_phase = 1'b0;
            check("fld_data", wr_byte, v.bytes[111-8*b -: 8]); b++;
            phase_done = 1'b1; tick(); phase_done = 1'b0;
            check("gap_wr_en", wr_en, 0);
            check("gap_busy", busy, 1);
            tick();
            check("post_gap_wr_en", wr_en, 1);
        end
        check("cmd_cur_field", cur_field, 6);
        addr_phase = 1'b1; tick(); addr_phase = 1'b0;
        check("cmd_addr", wr_byte, v.bytes[111-8*b -: 8]); b++;
        data_phase = 1'b1; tick(); data_phase = 1'b0;
        check("cmd_data", wr_byte, v.bytes[111-8*b -: 8]);
        check("cmd_no_done_yet", wr_done, 0);
        phase_done = 1'b1; tick(); phase_done = 1'b0;
        check("done_pulse", wr_done, 1);
        check("done_busy", busy, 0);
        check("done_wr_en", wr_en, 0);
        tick();
        check("done_single", wr_done, 0);
        $display("[TB] vector %0d mode=%0d mask=%b: %0d fields then command", id, v.mode, v.mask, v.nf);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{mode: 1'b1, mask: 6'b111111, nf: 4'd6,
                    idx: {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
                    bytes: {8'h21, 8'h30, 8'h22, 8'h45, 8'h23, 8'h12, 8'h24, 8'h15,
                            8'h25, 8'h09, 8'h26, 8'h16, 8'hF1, 8'h01}};
        vecs[1] = '{mode: 1'b0, mask: 6'b111111, nf: 4'd3,
                    idx: {3'd0, 3'd1, 3'd2, 9'd0},
                    bytes: {8'h41, 8'h30, 8'h42, 8'h45, 8'h43, 8'h12, 8'hF2, 8'h01, 48'd0}};
        vecs[2] = '{mode: 1'b1, mask: 6'b000101, nf: 4'd2,
                    idx: {3'd0, 3'd2, 12'd0},
                    bytes: {8'h21, 8'h30, 8'h23, 8'h12, 8'hF1, 8'h01, 64'd0}};
        vecs[3] = '{mode: 1'b1, mask: 6'b000000, nf: 4'd0,
                    idx: 18'd0,
                    bytes: {8'hF1, 8'h01, 96'd0}};
        vecs[4] = '{mode: 1'b0, mask: 6'b101010, nf: 4'd1,
                    idx: {3'd1, 15'd0},
                    bytes: {8'h42, 8'h45, 8'hF2, 8'h01, 80'd0}};

        reset      = 1'b1;
        start      = 1'b0;
        mode_clk   = 1'b0;
        field_mask = '0;
        field_data = {8'h16, 8'h09, 8'h15, 8'h12, 8'h45, 8'h30};
        addr_phase = 1'b0;
        data_phase = 1'b0;
        phase_done = 1'b0;
        abort      = 1'b0;
        tick();
        tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_byte", wr_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_field", cur_field, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Strobes in IDLE leave wr_byte alone.
        addr_phase = 1'b1; data_phase = 1'b1; tick();
        addr_phase = 1'b0; data_phase = 1'b0;
        check("idle_strobe_byte", wr_byte, 8'h01);
        check("idle_strobe_wr_en", wr_en, 0);

        // Start while busy is ignored; strobe priority; abort beats phase_done.
        mode_clk = 1'b1; field_mask = 6'b111111; start = 1'b1; tick();
        start = 1'b1; mode_clk = 1'b0; field_mask = 6'b000000; addr_phase = 1'b1; tick();
        start = 1'b0; addr_phase = 1'b0;
        check("busy_start_addr", wr_byte, 8'h21);
        check("busy_start_field", cur_field, 0);
        phase_done = 1'b1; tick(); phase_done = 1'b0;
        tick();
        addr_phase = 1'b1; data_phase = 1'b1; phase_done = 1'b1; tick();
        addr_phase = 1'b0;
        check("prio_addr_byte", wr_byte, 8'h22);
        check("prio_addr_wr_en", wr_en, 1);
        tick();
        data_phase = 1'b0;
        check("prio_data_byte", wr_byte, 8'h45);
        check("prio_data_wr_en", wr_en, 1);
        tick();
        phase_done = 1'b0;
        check("prio_done_gap", wr_en, 0);
        tick();
        check("abort_field_idx", cur_field, 2);
        abort = 1'b1; phase_done = 1'b1; tick();
        abort = 1'b0; phase_done = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_no_done", wr_done, 0);
        tick();
        check("abort_no_done_late", wr_done, 0);
        $display("[TB] abort/priority sequence complete");

        // Asynchronous reset in the middle of CMD.
        mode_clk = 1'b1; field_mask = 6'b000000; start = 1'b1; tick();
        start = 1'b0;
        addr_phase = 1'b1; tick(); addr_phase = 1'b0;
        check("pre_rst_cmd_addr", wr_byte, 8'hF1);
        reset = 1'b1;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_byte", wr_byte, 0);
        check("arst_busy", busy, 0);
        check("arst_cur_field", cur_field, 0);
        check("arst_wr_done", wr_done, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_no_done", wr_done, 0);
        $display("[TB] mid-CMD reset sequence complete");

        // Non-BCD field 1.
        field_data[15:8] = 8'h5A;
        mode_clk = 1'b1; field_mask = 6'b000010; start = 1'b1; tick();
        start = 1'b0;
`ifdef RTC_WR_BCD_CHECK_EN
        check("bcd_err_pulse", err, 1);
        check("bcd_busy", busy, 0);
        check("bcd_wr_en", wr_en, 0);
        tick();
        check("bcd_err_single", err, 0);
        check("bcd_busy_late", busy, 0);
`else
        check("nobcd_err", err, 0);
        check("nobcd_busy", busy, 1);
        check("nobcd_field", cur_field, 1);
        addr_phase = 1'b1; tick(); addr_phase = 1'b0;
        check("nobcd_addr", wr_byte, 8'h22);
        data_phase = 1'b1; tick(); data_phase = 1'b0;
        check("nobcd_data", wr_byte, 8'h5A);
        phase_done = 1'b1; tick(); phase_done = 1'b0;
        tick();
        check("nobcd_cmd_field", cur_field, 6);
        phase_done = 1'b1; tick(); phase_done = 1'b0;
        check("nobcd_done", wr_done, 1);
`endif
        $display("[TB] BCD field sequence complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_wr_sequencer.md
Name: rtc_wr_sequencer

Overview:
- Parametrised write sequencer for the RTC register file. It supersedes the fixed six-field clock/timer writer.
- On `start`, walks a masked list of time fields and presents each field's address byte, then its data byte, to the bus controller; then issues the RAM-to-clock or RAM-to-timer transfer command.
- Sits between the main control FSM (`start`, `mode_clk`, field values) and the bus controller (address/data/advance strobes).

Parameters:
- DATA_W, 8, width of address/data bytes and of each field.
- N_FIELDS, 6, clock-mode field count (sec, min, hour, day, month, year).
- TMR_FIELDS, 3, timer-mode field count (fields 0..TMR_FIELDS-1); must be <= N_FIELDS.
- CLK_BASE_ADDR, 8'h21, address of clock field 0; field i is at CLK_BASE_ADDR+i.
- TMR_BASE_ADDR, 8'h41, address of timer field 0; field i is at TMR_BASE_ADDR+i.
- CMD_CLK_ADDR, 8'hF1, transfer-command address in clock mode.
- CMD_TMR_ADDR, 8'hF2, transfer-command address in timer mode.
- CMD_DATA, 8'h01, transfer-command data byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a write sequence
- mode_clk  in  1  1 = clock target (N_FIELDS fields), 0 = timer target (TMR_FIELDS fields); sampled on accepted start
- field_mask  in  N_FIELDS  bit i = 1 writes field i; sampled on accepted start
- field_data  in  N_FIELDS*DATA_W  field i occupies bits [i*DATA_W +: DATA_W]; must be held stable while busy
- addr_phase  in  1  bus controller requests the address byte
- data_phase  in  1  bus controller requests the data byte
- phase_done  in  1  bus controller finished the current field or command
- abort  in  1  cancel the sequence
- wr_en  out  1  write request to the bus controller (registered)
- wr_byte  out  DATA_W  address/data byte (registered)
- busy  out  1  sequence in progress
- cur_field  out  $clog2(N_FIELDS+1)  index being written; N_FIELDS during the command phase
- wr_done  out  1  one-cycle pulse, sequence completed
- err  out  1  one-cycle pulse, start rejected (BCD_CHECK_EN only)

Behaviour:
- Reset: all outputs 0; state IDLE; latched mask/mode cleared. Reset during a sequence returns to IDLE immediately; no wr_done.
- FSM states: IDLE, FIELD, GAP, CMD.
- IDLE:
  - start=1 latches mode_clk and the effective mask: field_mask, with bits >= TMR_FIELDS forced to 0 in timer mode.
  - Next cycle: FIELD at the lowest set bit, or CMD if the effective mask is 0.
  - busy=1 from that cycle onward.
  - Strobes are ignored in IDLE.
- FIELD:
  - wr_en=1.
  - Strobe priority: addr_phase > data_phase > phase_done.
  - addr_phase: wr_byte <= base+cur_field (base per mode).
  - data_phase: wr_byte <= field cur_field.
  - phase_done: wr_en <= 0, go to GAP.
- GAP:
  - Exactly one cycle, wr_en=0.
  - Then FIELD at the next set bit above cur_field; otherwise CMD with cur_field=N_FIELDS.
- CMD:
  - wr_en=1.
  - addr_phase: wr_byte <= CMD_CLK_ADDR or CMD_TMR_ADDR per latched mode.
  - data_phase: wr_byte <= CMD_DATA.
  - phase_done: wr_done=1 for one cycle, wr_en=0, busy=0, return to IDLE.
- wr_byte holds its last value when no strobe is active.
- start while busy: ignored, no queuing.
- abort in FIELD, GAP or CMD: the next cycle is IDLE with wr_en=0, busy=0, no wr_done. abort has priority over phase_done in the same cycle.
- Address arithmetic is modulo 2^DATA_W.
- Latency: start to first wr_en = 1 cycle. The full sequence cost is driven by the bus controller plus 1 GAP cycle per field.

Optional Feature:
- Macro: RTC_WR_BCD_CHECK_EN.
- Defined: on start, every masked field is checked for valid BCD (both nibbles <= 9).
  - Any invalid field: start is rejected, err pulses 1 cycle, FSM stays IDLE, busy stays 0.
- Undefined: no check; err is tied to 0.

Decomposition:
- Shared package `rtc_pkg`: FSM state encoding, default address constants (CLK_BASE_ADDR, TMR_BASE_ADDR, CMD_* values), field index names FLD_SEC..FLD_YEAR.
- Sub-module `rtc_field_pick`: combinational priority encoder. Inputs: mask and start index. Outputs: next set index and a found flag. Used at start and in GAP.

Test Plan:
- Clock mode, mask 6'b111111, field_data sec..year = 8'h30,8'h45,8'h12,8'h15,8'h09,8'h16; strobe addr/data/done per field -> wr_byte sequence 21,30,22,45,23,12,24,15,25,09,26,16,F1,01; wr_done pulse once; cur_field 0..5 then 6.
- Timer mode, mask 6'b111111 -> only fields 0..2 at 41,42,43; then command F2,01; fields 3..5 never written.
- Clock mode, mask 6'b000101 -> addresses 21 then 23 only; each field is followed by exactly one GAP cycle with wr_en=0.
- Mask 0 -> CMD entered 1 cycle after start; wr_byte F1 then 01; wr_done.
- abort asserted in FIELD index 2 together with phase_done -> IDLE next cycle, busy=0, no wr_done. A second start while busy is ignored. Reset asserted mid-CMD -> all outputs 0 asynchronously.
- With RTC_WR_BCD_CHECK_EN: field 1 = 8'h5A -> err pulse, busy stays 0. Same stimulus without the macro -> sequence runs and writes 5A.
